// File: rtl/nn_train_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// nn_train_sequencer_pkg : sample widths, element type and sequencer states
// Revision: 1.0
// ============================================================================
package nn_train_sequencer_pkg;

  localparam int DATA_W = 16;
  localparam int L1     = 2;
  localparam int L4     = 1;

  typedef logic signed [DATA_W-1:0] data_type;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_INIT_RST  = 4'd1,
    ST_SETUP1    = 4'd2,
    ST_LOAD      = 4'd3,
    ST_SETUP2    = 4'd4,
    ST_STREAM    = 4'd5,
    ST_DRAIN     = 4'd6,
    ST_EPOCH_RST = 4'd7,
    ST_DONE      = 4'd8
  } seq_state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nn_seq_timer.sv
`default_nettype none
// ============================================================================
// nn_seq_timer : loadable down-counter that parks at zero and flags it
// Revision: 1.0
// ============================================================================
module nn_seq_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/nn_train_sequencer.sv
`default_nettype none
// ============================================================================
// nn_train_sequencer : streams training samples into neural_network and
//                      generates its init, load, enable and epoch controls
// Revision: 1.0
// ============================================================================
module nn_train_sequencer
  import nn_train_sequencer_pkg::*;
#(
  parameter int SAMPLES      = 2048,
  parameter int EPOCHS       = 100,
  parameter int HOLD_CYCLES  = 10,
  parameter int RST_CYCLES   = 10,
  parameter int SETUP_CYCLES = 10,
  parameter int DRAIN_CYCLES = 200
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [L1*DATA_W-1:0]         s_a1,
  input  logic [L4*DATA_W-1:0]         s_y,
  output logic [L1*DATA_W-1:0]         a1,
  output logic [L4*DATA_W-1:0]         y,
  output logic                         net_reset,
  output logic                         block_reset_on_mux,
  output logic                         load_inital_parameters,
  output logic                         input_select,
  output logic                         en_forward,
  output logic                         en_backward,
  output logic [$clog2(EPOCHS+1)-1:0]  epoch_count,
  output logic [$clog2(SAMPLES+1)-1:0] sample_count,
  output logic                         busy,
  output logic                         done,
  output logic                         underrun
);

  localparam int C_EPOCH_W = $clog2(EPOCHS+1);
  localparam int C_SAMP_W  = $clog2(SAMPLES+1);
  localparam int C_TMR_W   = $clog2(max4(HOLD_CYCLES, RST_CYCLES, SETUP_CYCLES, DRAIN_CYCLES) + 1);

  // Windows are loaded with N-1 so the zero cycle is the last cycle of the window
  localparam logic [C_TMR_W-1:0]   C_HOLD_LD   = C_TMR_W'(HOLD_CYCLES - 1);
  localparam logic [C_TMR_W-1:0]   C_RST_LD    = C_TMR_W'(RST_CYCLES - 1);
  localparam logic [C_TMR_W-1:0]   C_SETUP_LD  = C_TMR_W'(SETUP_CYCLES - 1);
  localparam logic [C_TMR_W-1:0]   C_DRAIN_LD  = C_TMR_W'(DRAIN_CYCLES - 1);
  localparam logic [C_SAMP_W-1:0]  C_SAMP_MAX  = C_SAMP_W'(SAMPLES);
  localparam logic [C_EPOCH_W-1:0] C_EPOCH_MAX = C_EPOCH_W'(EPOCHS);
  localparam logic [C_EPOCH_W-1:0] C_EPOCH_FIN = C_EPOCH_W'(EPOCHS - 1);

  seq_state_t           r_state;
  logic                 r_held;
  logic                 w_zero;
  logic                 w_tmr_load;
  logic [C_TMR_W-1:0]   w_tmr_value;
  logic                 w_take;
  logic                 w_hold_end;
  logic                 w_epoch_full;

  assign w_epoch_full = (sample_count == C_SAMP_MAX);
  assign w_hold_end   = r_held && w_zero;
  assign s_ready      = (r_state == ST_STREAM) && !w_epoch_full && (!r_held || w_zero);
  assign w_take       = s_valid && s_ready;

  always_comb begin
    w_tmr_load  = 1'b0;
    w_tmr_value = '0;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) begin w_tmr_load = 1'b1; w_tmr_value = C_RST_LD; end
      ST_INIT_RST:      if (w_zero) begin w_tmr_load = 1'b1; w_tmr_value = C_SETUP_LD; end
      ST_LOAD:          begin w_tmr_load = 1'b1; w_tmr_value = C_SETUP_LD; end
      ST_STREAM: begin
        if (w_take) begin
          w_tmr_load  = 1'b1;
          w_tmr_value = C_HOLD_LD;
        end else if (w_hold_end && w_epoch_full) begin
          w_tmr_load  = 1'b1;
          w_tmr_value = C_DRAIN_LD;
        end
      end
      ST_DRAIN:         if (w_zero) begin w_tmr_load = 1'b1; w_tmr_value = C_RST_LD; end
      default:          ;
    endcase
  end

  nn_seq_timer #(
    .WIDTH (C_TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (w_tmr_load),
    .load_value (w_tmr_value),
    .zero       (w_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state                <= ST_IDLE;
      r_held                 <= 1'b0;
      net_reset              <= 1'b1;
      block_reset_on_mux     <= 1'b0;
      load_inital_parameters <= 1'b0;
      input_select           <= 1'b0;
      en_forward             <= 1'b0;
      en_backward            <= 1'b0;
      a1                     <= '0;
      y                      <= '0;
      epoch_count            <= '0;
      sample_count           <= '0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      underrun               <= 1'b0;
    end else begin
      load_inital_parameters <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state            <= ST_INIT_RST;
            r_held             <= 1'b0;
            net_reset          <= 1'b0;
            block_reset_on_mux <= 1'b0;
            input_select       <= 1'b0;
            en_forward         <= 1'b0;
            en_backward        <= 1'b0;
            epoch_count        <= '0;
            sample_count       <= '0;
            busy               <= 1'b1;
            done               <= 1'b0;
            underrun           <= 1'b0;
          end
        end
        ST_INIT_RST: begin
          if (w_zero) begin
            r_state            <= ST_SETUP1;
            net_reset          <= 1'b1;
            block_reset_on_mux <= 1'b1;
          end
        end
        ST_SETUP1: begin
          if (w_zero) begin
            r_state                <= ST_LOAD;
            load_inital_parameters <= 1'b1;
          end
        end
        ST_LOAD: r_state <= ST_SETUP2;
        ST_SETUP2: begin
          if (w_zero) begin
            r_state     <= ST_STREAM;
            en_forward  <= 1'b1;
            en_backward <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (w_take) begin
            a1           <= s_a1;
            y            <= s_y;
            r_held       <= 1'b1;
            en_forward   <= 1'b1;
            en_backward  <= 1'b1;
            sample_count <= sample_count + C_SAMP_W'(1);
          end else if (w_hold_end) begin
            r_held <= 1'b0;
            if (w_epoch_full) begin
              r_state <= ST_DRAIN;
            end else begin
              // Starved: freeze the network on the last sample until data returns
              en_forward  <= 1'b0;
              en_backward <= 1'b0;
              underrun    <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (w_zero) begin
            r_state     <= ST_EPOCH_RST;
            net_reset   <= 1'b0;
            en_forward  <= 1'b0;
            en_backward <= 1'b0;
          end
        end
        ST_EPOCH_RST: begin
          if (w_zero) begin
            net_reset    <= 1'b1;
            input_select <= 1'b1;
            sample_count <= '0;
            if (epoch_count != C_EPOCH_MAX) epoch_count <= epoch_count + C_EPOCH_W'(1);
            if (epoch_count >= C_EPOCH_FIN) begin
              r_state <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_state     <= ST_STREAM;
              en_forward  <= 1'b1;
              en_backward <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nn_train_sequencer.sv
`default_nettype none
// ============================================================================
// tb_nn_train_sequencer : self-checking bench for nn_train_sequencer
// Revision: 1.0
// ============================================================================
module tb_nn_train_sequencer;
  import nn_train_sequencer_pkg::*;

  localparam int SAMPLES = 4;
  localparam int EPOCHS  = 2;
  localparam int HOLD    = 3;
  localparam int RSTC    = 2;
  localparam int SETUP   = 2;
  localparam int DRAIN   = 5;
  localparam int AW      = L1*DATA_W;
  localparam int YW      = L4*DATA_W;
  localparam int EW      = $clog2(EPOCHS+1);
  localparam int SW      = $clog2(SAMPLES+1);

  localparam logic [AW-1:0] CONST_A1 = {16'(1013), 16'(-4750)};
  localparam logic [YW-1:0] CONST_Y  = 16'(4096);
  localparam logic [AW-1:0] DIR_A1   = {16'(-1555), 16'(250)};

  logic          clk = 1'b0;
  logic          reset, start, s_valid, s_ready;
  logic [AW-1:0] s_a1, a1;
  logic [YW-1:0] s_y, y;
  logic          net_reset, block_reset_on_mux, load_inital_parameters, input_select;
  logic          en_forward, en_backward, busy, done, underrun;
  logic [EW-1:0] epoch_count;
  logic [SW-1:0] sample_count;

  always #5 clk = ~clk;

  nn_train_sequencer #(
    .SAMPLES(SAMPLES), .EPOCHS(EPOCHS), .HOLD_CYCLES(HOLD),
    .RST_CYCLES(RSTC), .SETUP_CYCLES(SETUP), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_a1(s_a1), .s_y(s_y),
    .a1(a1), .y(y), .net_reset(net_reset), .block_reset_on_mux(block_reset_on_mux),
    .load_inital_parameters(load_inital_parameters), .input_select(input_select),
    .en_forward(en_forward), .en_backward(en_backward),
    .epoch_count(epoch_count), .sample_count(sample_count),
    .busy(busy), .done(done), .underrun(underrun)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference state that outlives a single epoch
  logic [AW-1:0] exp_a1;
  logic [YW-1:0] exp_y;
  logic          exp_underrun;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [9:0] status();
    return {net_reset, block_reset_on_mux, load_inital_parameters, input_select,
            en_forward, en_backward, busy, done, underrun, s_ready};
  endfunction

  task automatic test_reset();
    checks++;
    if (status() !== 10'b10_0000_0000) begin
      errors++; $display("FAIL reset_status: got %b expected %b", status(), 10'b10_0000_0000);
    end
    checks++;
    if ({a1, y, epoch_count, sample_count} !== '0) begin
      errors++; $display("FAIL reset_data: a1=%h y=%h epoch=%0d samples=%0d expected all 0",
                         a1, y, epoch_count, sample_count);
    end
  endtask

  task automatic test_init_sequence();
    int last = RSTC + 2*SETUP + 2;
    int low_cnt = 0;
    int load_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= last; k++) begin
      logic [8:0] e;
      e = {1'b0 == (k <= RSTC), k > RSTC, k == RSTC+SETUP+1, 1'b0, k == last, k == last,
           1'b1, 1'b0, 1'b0};
      checks++;
      if (status()[9:1] !== e) begin
        errors++; $display("FAIL init_cycle%0d: got %b expected %b", k, status()[9:1], e);
      end
      low_cnt  += int'(!net_reset);
      load_cnt += int'(load_inital_parameters);
      if (k != last) step();
    end
    checks++;
    if (low_cnt != RSTC || load_cnt != 1) begin
      errors++; $display("FAIL init_widths: net_reset low %0d load %0d expected %0d and 1",
                         low_cnt, load_cnt, RSTC);
    end
    checks++;
    if (epoch_count !== '0 || sample_count !== '0) begin
      errors++; $display("FAIL init_counts: epoch=%0d samples=%0d expected 0", epoch_count, sample_count);
    end
  endtask

  task automatic test_abort_mid_stream();
    s_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_a1 = AW'($urandom());
      s_y  = YW'($urandom());
      step();
    end
    reset = 1'b0;
    #1;
    checks++;
    if (status() !== 10'b10_0000_0000) begin
      errors++; $display("FAIL abort_status: got %b expected %b", status(), 10'b10_0000_0000);
    end
    checks++;
    if ({a1, y, epoch_count, sample_count} !== '0) begin
      errors++; $display("FAIL abort_data: a1=%h y=%h samples=%0d expected 0", a1, y, sample_count);
    end
    exp_a1 = '0; exp_y = '0; exp_underrun = 1'b0;
    s_valid = 1'b0;
    #2 reset = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      errors++; $display("FAIL abort_idle: busy=%b s_ready=%b expected 0 0", busy, s_ready);
    end
  endtask

  task automatic test_start_while_busy();
    s_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({net_reset, load_inital_parameters, busy, en_forward, s_ready} !== 5'b10111 ||
          sample_count !== '0) begin
        errors++; $display("FAIL start_ignored: ctl=%b samples=%0d expected 10111 and 0",
                           {net_reset, load_inital_parameters, busy, en_forward, s_ready}, sample_count);
      end
      if (k < 2) step();
    end
  endtask

  // directed=0: continuous valid with fixed data; directed=1: random data and
  // gaps plus a forced 4-clock starvation right after the second sample
  task automatic test_epoch(input int ep, input bit directed);
    bit      held = 1'b0;
    bit      leave = 1'b0;
    bit      exp_en = 1'b1;
    int      age = 0;
    int      n_acc = 0;
    int      stall = 0;
    int      last_hs = 0;
    int      guard = 0;
    logic    exp_ready, v;
    logic [AW-1:0] da;
    logic [YW-1:0] dy;
    while (!leave) begin
      exp_ready = (n_acc < SAMPLES) && (!held || age == HOLD);
      checks++;
      if ({s_ready, en_forward, en_backward, underrun, input_select, busy} !==
          {exp_ready, exp_en, exp_en, exp_underrun, ep > 0, 1'b1}) begin
        errors++; $display("FAIL ep%0d_ctl c%0d: ready/enf/enb/underrun/sel/busy=%b expected %b", ep, cyc,
          {s_ready, en_forward, en_backward, underrun, input_select, busy},
          {exp_ready, exp_en, exp_en, exp_underrun, ep > 0, 1'b1});
      end
      checks++;
      if (a1 !== exp_a1 || y !== exp_y || sample_count !== SW'(n_acc)) begin
        errors++; $display("FAIL ep%0d_data c%0d: a1=%h y=%h n=%0d expected %h %h %0d", ep, cyc,
                           a1, y, sample_count, exp_a1, exp_y, n_acc);
      end
      if (directed && !exp_en && n_acc == 2) begin
        checks++;
        if (a1 !== DIR_A1) begin
          errors++; $display("FAIL underrun_hold: a1=%h expected %h", a1, DIR_A1);
        end
      end
      if (!directed) begin
        v = 1'b1; da = CONST_A1; dy = CONST_Y;
      end else begin
        v  = ($urandom_range(0, 3) != 0);
        da = (n_acc == 1) ? DIR_A1 : AW'($urandom());
        dy = YW'($urandom());
        if (stall > 0) begin v = 1'b0; stall--; end
      end
      s_valid = v; s_a1 = da; s_y = dy;
      if (v && exp_ready) begin
        if (!directed && n_acc > 0) begin
          checks++;
          if (cyc - last_hs != HOLD) begin
            errors++; $display("FAIL hs_spacing: got %0d expected %0d", cyc - last_hs, HOLD);
          end
        end
        last_hs = cyc;
        held = 1'b1; age = 1; n_acc++;
        exp_a1 = da; exp_y = dy; exp_en = 1'b1;
        if (directed && n_acc == 2) stall = 4;
      end else if (held && age == HOLD) begin
        held = 1'b0;
        if (n_acc == SAMPLES) leave = 1'b1;
        else begin exp_en = 1'b0; exp_underrun = 1'b1; end
      end else if (held) begin
        age++;
      end
      step();
      guard++;
      if (guard > 200) begin
        errors++; $display("FAIL ep%0d_timeout: accepted %0d expected %0d", ep, n_acc, SAMPLES);
        return;
      end
    end
    s_valid = 1'b0;
    for (int k = 0; k < DRAIN; k++) begin
      checks++;
      if ({en_forward, en_backward, s_ready, net_reset} !== 4'b1101) begin
        errors++; $display("FAIL ep%0d_drain%0d: en/en/ready/nrst=%b expected 1101", ep, k,
                           {en_forward, en_backward, s_ready, net_reset});
      end
      step();
    end
    for (int k = 0; k < RSTC; k++) begin
      checks++;
      if (net_reset !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL ep%0d_rst%0d: net_reset=%b busy=%b expected 0 1", ep, k, net_reset, busy);
      end
      step();
    end
    checks++;
    if ({net_reset, input_select} !== 2'b11 || epoch_count !== EW'(ep + 1) || sample_count !== '0) begin
      errors++; $display("FAIL ep%0d_end: nrst/sel=%b epoch=%0d samples=%0d expected 11 %0d 0", ep,
                         {net_reset, input_select}, epoch_count, sample_count, ep + 1);
    end
    checks++;
    if ({done, busy, en_forward} !== ((ep + 1 == EPOCHS) ? 3'b100 : 3'b011)) begin
      errors++; $display("FAIL ep%0d_next: done/busy/en=%b expected %b", ep, {done, busy, en_forward},
                         (ep + 1 == EPOCHS) ? 3'b100 : 3'b011);
    end
  endtask

  task automatic test_restart_from_done();
    step();
    step();
    checks++;
    if ({busy, done, underrun, en_forward} !== {1'b0, 1'b1, exp_underrun, 1'b0} ||
        epoch_count !== EW'(EPOCHS)) begin
      errors++; $display("FAIL done_sticky: busy/done/underrun/en=%b epoch=%0d expected %b %0d",
                         {busy, done, underrun, en_forward}, epoch_count,
                         {1'b0, 1'b1, exp_underrun, 1'b0}, EPOCHS);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({busy, done, underrun, net_reset} !== 4'b1000 || epoch_count !== '0 || sample_count !== '0) begin
      errors++; $display("FAIL restart: busy/done/underrun/nrst=%b epoch=%0d samples=%0d expected 1000 0 0",
                         {busy, done, underrun, net_reset}, epoch_count, sample_count);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; s_valid = 1'b0; s_a1 = '0; s_y = '0;
    exp_a1 = '0; exp_y = '0; exp_underrun = 1'b0;
    step();
    step();
    test_reset();
    reset = 1'b1;
    step();
    test_init_sequence();
    test_abort_mid_stream();
    test_init_sequence();
    test_start_while_busy();
    test_epoch(0, 1'b0);
    test_epoch(1, 1'b1);
    test_restart_from_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
